add_seq_unit: RTL and testbench
===============================

# add_seq_unit

Parametrised, multi-cycle add/subtract unit with flag generation; the sequential successor of the single-cycle 32-bit adder in the ALU. It processes CHUNK bits per clock over WIDTH/CHUNK cycles and supports signed or unsigned add and subtract. Operands enter and results leave through valid/ready handshakes, so the unit can sit behind an issue stage and stall the pipeline. It produces the S, Z, V and N outputs the ALU already consumes.

## Interface

- WIDTH, 32: operand and result width; must be >= 2.
- CHUNK, 8: bits processed per cycle; WIDTH % CHUNK must equal 0; NCYC = WIDTH/CHUNK.
- clk input 1: single clock; all state changes on its rising edge.
- rst_n input 1: asynchronous, active-low reset.
- in_valid input 1: an operand set is present on a, b, sign and sub.
- in_ready output 1: the unit accepts an operand set; equals 1 exactly when the state is IDLE.
- a input WIDTH: first operand.
- b input WIDTH: second operand.
- sign input 1: 1 selects two's-complement interpretation; 0 selects unsigned.
- sub input 1: 1 computes a − b; 0 computes a + b.
- out_valid output 1: s, z, v and n hold a completed result.
- out_ready input 1: the consumer takes the result.
- s output WIDTH: result (wrapped, or saturated when the saturation feature is compiled in).
- z output 1: s equals 0.
- v output 1: the true result does not fit the selected interpretation.
- n output 1: the true mathematical result is negative.

## Operation

- The state machine has three states: IDLE, RUN and DONE.
- **IDLE:**
  - When in_valid is 1, the unit captures a, b (inverted if sub is 1), sign and sub.
  - It sets carry to sub and the chunk counter to 0, then moves to RUN.
- **RUN:**
  - Each cycle adds one CHUNK slice, starting at the LSB, with the registered carry.
  - It stores the slice into s and updates carry.
  - When the counter reaches NCYC−1, it registers the flags and moves to DONE.
- **DONE:**
  - out_valid is 1 and in_ready is 0.
  - On the edge where out_ready is 1, the unit moves to IDLE.
- **Flags:**
  - z = (s == 0). Z is computed after saturation.
  - Unsigned add: v = carry-out; n = 0.
  - Unsigned subtract: v = borrow (that is, NOT carry-out); n = borrow.
  - Signed (add or subtract): v = carry into MSB XOR carry-out; n = s[MSB] XOR v, which is the sign of the unwrapped result.
- in_valid is ignored outside IDLE, and operand inputs are not sampled outside IDLE.
- s, z, v and n hold their last values until the next completion. They are meaningful only while out_valid is 1.

## Timing

- **Reset:** While rst_n is low, the state is IDLE, and s, z, v, n, out_valid, the counter and carry are all 0. in_ready reads 1, but no handshake is honoured while reset is asserted.
- **Latency:** If the operands are accepted at edge k, out_valid rises after edge k+NCYC.
- **Back-to-back:** A result handshake at edge m puts the unit in IDLE after m. The earliest next acceptance is edge m+1. Minimum issue interval is NCYC+2 cycles.
- **Backpressure:** While out_ready is 0 in DONE, the outputs stay stable indefinitely.
- **Reset mid-operation:** If rst_n falls in RUN or DONE, the operation is discarded immediately. No partial result is ever signalled valid.
- **NCYC = 1 (CHUNK = WIDTH):** RUN lasts exactly one cycle.

## Configuration

- Macro: ADD_SEQ_SAT_EN.
- **Defined:** When v = 1 on completion, s is replaced by a saturated value:
  - Unsigned add: all ones.
  - Unsigned subtract: 0.
  - Signed with n = 0: 0 followed by ones (maximum positive value).
  - Signed with n = 1: 1 followed by zeros (minimum negative value).
  - v and n are still reported; z is evaluated on the saturated s.
- **Undefined:** s is always the wrapped WIDTH-bit result. No saturation logic is synthesised.

## Structure

- Shared package add_pkg contains:
  - the state enum (IDLE, RUN, DONE);
  - the helper function computing the saturation constants for a given width.
- Sub-module add_chunk: a combinational CHUNK-bit ripple slice with inputs (x, y, cin) and outputs (sum, cout, c_msb_in). c_msb_in is the carry into the slice MSB and is used for signed overflow on the final slice. It is instantiated once.
- Elaboration check: fail if WIDTH % CHUNK != 0 or WIDTH < 2.

## Test plan

All scenarios use WIDTH=32, CHUNK=8, so NCYC=4.

- **Unsigned add with carry:** 0xFFFFFFFF + 0x00000001 -> s=0, z=1, v=1, n=0; out_valid rises 4 edges after acceptance. With ADD_SEQ_SAT_EN: s=0xFFFFFFFF, z=0.
- **Signed add overflow:** 0x7FFFFFFF + 1 -> s=0x80000000, v=1, n=0. With ADD_SEQ_SAT_EN: s=0x7FFFFFFF.
- **Signed subtract:** 5 − 7 -> s=0xFFFFFFFE, v=0, n=1, z=0. Signed 0x80000000 − 1 -> v=1, n=1; with ADD_SEQ_SAT_EN s=0x80000000.
- **Unsigned subtract with borrow:** 3 − 5 -> s=0xFFFFFFFE, v=1, n=1. With ADD_SEQ_SAT_EN: s=0, z=1.
- **Backpressure:** hold out_ready=0 for 10 cycles while toggling in_valid and a -> s and flags stay constant and in_ready=0. Release out_ready -> handshake occurs, then in_ready=1 on the next cycle.
- **Reset mid-run:** pulse rst_n low during the second RUN cycle -> all outputs read 0 asynchronously and out_valid never rises. After release, a fresh operation 2 + 2 completes with s=4.

Source files
------------

// File: rtl/add_pkg.sv
// rtl/add_pkg.sv - shared states and saturation constants for add_seq_unit (macro ADD_SEQ_SAT_EN)
package add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Widest operand the saturation helpers can describe; callers size-cast down.
    localparam int SAT_MAX_W = 256;

    // Largest positive two's-complement value of width w: 0 followed by ones.
    function automatic logic [SAT_MAX_W-1:0] sat_max_pos(input int w);
        logic [SAT_MAX_W-1:0] m;
        m = '0;
        for (int i = 0; i < w - 1; i++) begin
            m[i] = 1'b1;
        end
        return m;
    endfunction

    // Most negative two's-complement value of width w: 1 followed by zeros.
    function automatic logic [SAT_MAX_W-1:0] sat_min_neg(input int w);
        logic [SAT_MAX_W-1:0] m;
        m = '0;
        m[w-1] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/add_chunk.sv
// rtl/add_chunk.sv - combinational CHUNK-bit ripple slice with carry into its MSB
module add_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK:0] full;

    // One wide add; the MSB carry-in is recovered as x^y^sum at the top bit.
    always_comb begin
        full     = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
        sum      = full[CHUNK-1:0];
        cout     = full[CHUNK];
        c_msb_in = x[CHUNK-1] ^ y[CHUNK-1] ^ full[CHUNK-1];
    end

endmodule

// File: rtl/add_seq_unit.sv
// rtl/add_seq_unit.sv - multi-cycle add/subtract with S/Z/V/N flags, optional saturation via ADD_SEQ_SAT_EN
module add_seq_unit
    import add_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sign,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             z,
    output logic             v,
    output logic             n
);

    localparam int NCYC = WIDTH / CHUNK;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCYC - 1);

    generate
        if ((WIDTH % CHUNK) != 0 || WIDTH < 2) begin : g_bad_params
            $error("add_seq_unit: WIDTH must be >= 2 and a multiple of CHUNK");
        end
    endgenerate

`ifdef ADD_SEQ_SAT_EN
    localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_max_pos(WIDTH));
    localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(sat_min_neg(WIDTH));
`endif

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [WIDTH-1:0]  acc;
    logic              sign_r;
    logic              sub_r;
    logic              carry;
    logic [CW-1:0]     cnt;

    logic [CHUNK-1:0]  slice_sum;
    logic              slice_cout;
    logic              slice_cmsb;
    logic [WIDTH-1:0]  res_w;
    logic [WIDTH-1:0]  s_c;
    logic              v_c;
    logic              n_c;
    logic              z_c;

    add_chunk #(.CHUNK(CHUNK)) u_chunk (
        .x        (a_r[cnt*CHUNK +: CHUNK]),
        .y        (b_r[cnt*CHUNK +: CHUNK]),
        .cin      (carry),
        .sum      (slice_sum),
        .cout     (slice_cout),
        .c_msb_in (slice_cmsb)
    );

    // Wrapped result with the current slice merged in; complete on the last RUN cycle.
    always_comb begin
        res_w = acc;
        res_w[cnt*CHUNK +: CHUNK] = slice_sum;
    end

    // Flag generation from the final slice carries, then optional saturation and zero test.
    always_comb begin
        v_c = 1'b0;
        n_c = 1'b0;
        s_c = res_w;
        case ({sign_r, sub_r})
            2'b00: begin
                v_c = slice_cout;
                n_c = 1'b0;
            end
            2'b01: begin
                v_c = ~slice_cout;
                n_c = ~slice_cout;
            end
            default: begin
                v_c = slice_cmsb ^ slice_cout;
                n_c = res_w[WIDTH-1] ^ (slice_cmsb ^ slice_cout);
            end
        endcase
`ifdef ADD_SEQ_SAT_EN
        if (v_c) begin
            if (!sign_r) begin
                s_c = sub_r ? '0 : '1;
            end else begin
                s_c = n_c ? SAT_NEG : SAT_POS;
            end
        end
`endif
        z_c = (s_c == '0);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, chunk sequencing and result/flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            acc    <= '0;
            sign_r <= 1'b0;
            sub_r  <= 1'b0;
            carry  <= 1'b0;
            cnt    <= '0;
            s      <= '0;
            z      <= 1'b0;
            v      <= 1'b0;
            n      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r    <= a;
                        b_r    <= sub ? ~b : b;
                        sign_r <= sign;
                        sub_r  <= sub;
                        carry  <= sub;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    acc   <= res_w;
                    carry <= slice_cout;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        s <= s_c;
                        z <= z_c;
                        v <= v_c;
                        n <= n_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_seq_unit.sv
// tb/tb_add_seq_unit.sv - scoreboard bench for add_seq_unit (honours ADD_SEQ_SAT_EN)
module tb_add_seq_unit;

    typedef struct packed {
        logic [31:0] s;
        logic        z;
        logic        v;
        logic        n;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        sign = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] s;
    logic        z;
    logic        v;
    logic        n;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    add_seq_unit #(.WIDTH(32), .CHUNK(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sign      (sign),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .z         (z),
        .v         (v),
        .n         (n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                   input logic msg, input logic msb);
        exp_t        e;
        logic [32:0] u;
        longint      ra;
        longint      rb;
        longint      r;
        if (!msg) begin
            u   = msb ? ({1'b0, ma} - {1'b0, mb}) : ({1'b0, ma} + {1'b0, mb});
            e.s = u[31:0];
            e.v = msb ? (ma < mb) : u[32];
            e.n = msb ? (ma < mb) : 1'b0;
`ifdef ADD_SEQ_SAT_EN
            if (e.v) e.s = msb ? 32'h0000_0000 : 32'hFFFF_FFFF;
`endif
        end else begin
            ra  = longint'($signed(ma));
            rb  = longint'($signed(mb));
            r   = msb ? (ra - rb) : (ra + rb);
            e.s = r[31:0];
            e.v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            e.n = (r < 0);
`ifdef ADD_SEQ_SAT_EN
            if (e.v) e.s = e.n ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        end
        e.z = (e.s == 32'h0);
        return e;
    endfunction

    task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                         input logic isg, input logic isb, input bit push);
        @(negedge clk);
        check("in_ready_at_issue", {31'b0, in_ready}, 32'd1);
        a = ia; b = ib; sign = isg; sub = isb; in_valid = 1'b1;
        if (push) sb_q.push_back(model(ia, ib, isg, isb));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        int lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, lat, 32'd4);
    endtask

    task automatic compare(input string tag);
        exp_t e;
        checks++;
        assert (sb_q.size() > 0) else begin
            errors++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, "_s"}, s, e.s);
            check({tag, "_z"}, {31'b0, z}, {31'b0, e.z});
            check({tag, "_v"}, {31'b0, v}, {31'b0, e.v});
            check({tag, "_n"}, {31'b0, n}, {31'b0, e.n});
        end
    endtask

    task automatic release_result(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_ov_after_hs"}, {31'b0, out_valid}, 32'd0);
        check({tag, "_rdy_after_hs"}, {31'b0, in_ready}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                          input logic isg, input logic isb);
        issue(ia, ib, isg, isb, 1'b1);
        wait_result(tag);
        compare(tag);
        release_result(tag);
    endtask

    initial begin
        logic [31:0] hold_s;
        logic [2:0]  hold_f;
        bit          saw_valid;

        #2;
        check("rst_s", s, 32'd0);
        check("rst_flags", {29'b0, z, v, n}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("uadd_carry", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_op("sadd_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b0);
        run_op("ssub_neg",   32'd5,         32'd7,         1'b1, 1'b1);
        run_op("ssub_min",   32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
        run_op("usub_brw",   32'd3,         32'd5,         1'b0, 1'b1);
        run_op("usub_eq",    32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1);
        run_op("sadd_negneg", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            run_op("rand", $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Backpressure: result must hold while out_ready stays low and inputs churn.
        issue(32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0, 1'b1);
        wait_result("bp");
        compare("bp");
        hold_s = s;
        hold_f = {z, v, n};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            a = $urandom;
            @(posedge clk);
            #1;
            check("bp_s_stable", s, hold_s);
            check("bp_flags_stable", {29'b0, z, v, n}, {29'b0, hold_f});
            check("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
            check("bp_out_valid_high", {31'b0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        release_result("bp");

        // Reset during the second RUN cycle: outputs clear at once, no result appears.
        run_op("pre_rst", 32'h0000_0010, 32'hFFFF_FFFF, 1'b0, 1'b0);
        issue(32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_s", s, 32'd0);
        check("mid_rst_flags", {29'b0, z, v, n}, 32'd0);
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) saw_valid = 1'b1;
        end
        check("mid_rst_no_valid", {31'b0, saw_valid}, 32'd0);
        issue(32'd2, 32'd2, 1'b0, 1'b0, 1'b1);
        wait_result("post_rst");
        check("post_rst_sum_four", s, 32'd4);
        compare("post_rst");
        release_result("post_rst");

        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
